// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - display port bundle between the reg0 source and seg7_scan
// master drives the word and freeze control; slave (seg7_scan) drives the display pins.
interface seg7_scan_if;
  logic [15:0] value;
  logic        freeze;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output value,
    output freeze,
    input  seg,
    input  dp,
    input  an,
    input  frame_done
  );

  modport slave (
    input  value,
    input  freeze,
    output seg,
    output dp,
    output an,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit multiplexed hex display scanner for a 16-bit word
// The word is latched only at frame boundaries so a frame never mixes old and new nibbles.
module seg7_scan #(
  parameter int unsigned CLK_DIV    = 50000,
  parameter bit          LZ_BLANK   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave disp
);
  localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             changed_q, changed_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q, frame_done_d;

  logic       tick;
  logic       boundary;
  logic       ghost;
  logic       blank;
  logic [3:0] nibble;
  logic [6:0] glyph;

  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    boundary     = tick && (idx_q == 2'd3);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shadow_d     = shadow_q;
    changed_d    = changed_q;
    frame_done_d = boundary;
    if (boundary) begin
      if (!disp.freeze) begin
        shadow_d  = disp.value;
        changed_d = (disp.value != shadow_q);
      end else begin
        changed_d = 1'b0;
      end
    end
  end

  // Digit 0 is never blanked; higher digits blank only when every nibble above them is zero too.
  always_comb begin
    nibble = shadow_q[3:0];
    blank  = 1'b0;
    case (idx_q)
      2'd0: begin
        nibble = shadow_q[3:0];
        blank  = 1'b0;
      end
      2'd1: begin
        nibble = shadow_q[7:4];
        blank  = LZ_BLANK && (shadow_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = shadow_q[11:8];
        blank  = LZ_BLANK && (shadow_q[15:8] == 8'h00);
      end
      default: begin
        nibble = shadow_q[15:12];
        blank  = LZ_BLANK && (shadow_q[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    glyph = 7'h00;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end

  // The first cycle of every slot is dark so the previous digit cannot ghost onto the next anode.
  always_comb begin
    ghost = (cnt_q == '0);
    an_d  = ghost ? 4'b0000 : (4'b0001 << idx_q);
    seg_d = (ghost || blank) ? 7'h00 : glyph;
    dp_d  = changed_q && (idx_q == 2'd0) && !ghost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      changed_q    <= 1'b0;
      an_q         <= 4'b0000;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      changed_q    <= changed_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp.an         = {4{ACTIVE_LOW}} ^ an_q;
  assign disp.seg        = {7{ACTIVE_LOW}} ^ seg_q;
  assign disp.dp         = ACTIVE_LOW ^ dp_q;
  assign disp.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed bench for seg7_scan
// dut0: no blanking, active-high pins; dut1: leading-zero blanking, active-low pins.
module tb_seg7_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        freeze;

  int nvec  = 0;
  int nfail = 0;

  logic [6:0]  g0 [4];
  logic [6:0]  g1 [4];
  logic        dp_exp;
  logic [12:0] e0, e1;
  bit          ok;

  always #5 clk = ~clk;

  seg7_scan_if bus0 ();
  seg7_scan_if bus1 ();

  assign bus0.value  = value;
  assign bus0.freeze = freeze;
  assign bus1.value  = value;
  assign bus1.freeze = freeze;

  seg7_scan #(.CLK_DIV(4), .LZ_BLANK(1'b0), .ACTIVE_LOW(1'b0)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .disp (bus0)
  );

  seg7_scan #(.CLK_DIV(4), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .disp (bus1)
  );

  logic [12:0] pins0, pins1;
  assign pins0 = {bus0.an, bus0.seg, bus0.dp, bus0.frame_done};
  assign pins1 = {bus1.an, bus1.seg, bus1.dp, bus1.frame_done};

  // k counts sample cycles after a frame_done: 1 dark, 2..4 digit 0, 5 dark, ... 16 is the next frame_done.
  function automatic logic [12:0] exp_pins(int k, logic dpx, logic inv);
    logic [1:0]  d;
    logic [6:0]  gl;
    logic [11:0] p;
    d  = 2'((k - 1) / 4);
    gl = inv ? g1[d] : g0[d];
    p  = 12'h000;
    if (((k - 1) % 4) != 0) p = {4'b0001 << d, gl, dpx && (d == 2'd0)};
    return {inv ? ~p : p, k == 16};
  endfunction

  task automatic wait_fd(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    freeze = 1'b0;
    value  = 16'h1234;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nvec += 2;
      if (pins0 !== 13'h0000) begin
        nfail++;
        $display("FAIL reset c%0d dut0 got %h want %h", c, pins0, 13'h0000);
      end
      if (pins1 !== 13'h1FFE) begin
        nfail++;
        $display("FAIL reset c%0d dut1 got %h want %h", c, pins1, 13'h1FFE);
      end
      if (c == 2) rst = 1'b0;
    end
  endtask

  task automatic test_scan();
    g0 = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    g1 = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    wait_fd(ok);
    nvec++;
    if (!ok) begin nfail++; $display("FAIL scan_wait got none want frame_done"); end
    for (int f = 0; f < 2; f++) begin
      dp_exp = (f == 0);
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        e0 = exp_pins(k, dp_exp, 1'b0);
        e1 = exp_pins(k, dp_exp, 1'b1);
        nvec += 2;
        if (pins0 !== e0) begin nfail++; $display("FAIL scan f%0d k%0d dut0 got %h want %h", f, k, pins0, e0); end
        if (pins1 !== e1) begin nfail++; $display("FAIL scan f%0d k%0d dut1 got %h want %h", f, k, pins1, e1); end
      end
    end
  endtask

  task automatic test_lz_blank();
    value = 16'h000A;
    g0 = '{7'h77, 7'h3F, 7'h3F, 7'h3F};
    g1 = '{7'h77, 7'h00, 7'h00, 7'h00};
    wait_fd(ok);
    nvec++;
    if (!ok) begin nfail++; $display("FAIL lz_wait got none want frame_done"); end
    for (int f = 0; f < 3; f++) begin
      dp_exp = (f != 1);
      if (f == 1) value = 16'h0000;
      if (f == 2) begin
        g0 = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
        g1 = '{7'h3F, 7'h00, 7'h00, 7'h00};
      end
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        e0 = exp_pins(k, dp_exp, 1'b0);
        e1 = exp_pins(k, dp_exp, 1'b1);
        nvec += 2;
        if (pins0 !== e0) begin nfail++; $display("FAIL lz f%0d k%0d dut0 got %h want %h", f, k, pins0, e0); end
        if (pins1 !== e1) begin nfail++; $display("FAIL lz f%0d k%0d dut1 got %h want %h", f, k, pins1, e1); end
      end
    end
  endtask

  task automatic test_tear_free();
    value = 16'h1111;
    g0 = '{7'h06, 7'h06, 7'h06, 7'h06};
    g1 = '{7'h06, 7'h06, 7'h06, 7'h06};
    wait_fd(ok);
    nvec++;
    if (!ok) begin nfail++; $display("FAIL tear_wait got none want frame_done"); end
    for (int f = 0; f < 3; f++) begin
      dp_exp = (f != 2);
      if (f == 1) begin
        g0 = '{7'h5B, 7'h5B, 7'h5B, 7'h5B};
        g1 = '{7'h5B, 7'h5B, 7'h5B, 7'h5B};
      end
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        e0 = exp_pins(k, dp_exp, 1'b0);
        e1 = exp_pins(k, dp_exp, 1'b1);
        nvec += 2;
        if (pins0 !== e0) begin nfail++; $display("FAIL tear f%0d k%0d dut0 got %h want %h", f, k, pins0, e0); end
        if (pins1 !== e1) begin nfail++; $display("FAIL tear f%0d k%0d dut1 got %h want %h", f, k, pins1, e1); end
        if (f == 0 && k == 10) value = 16'h2222;
      end
    end
  endtask

  task automatic test_freeze();
    value = 16'hABCD;
    g0 = '{7'h5E, 7'h39, 7'h7C, 7'h77};
    g1 = '{7'h5E, 7'h39, 7'h7C, 7'h77};
    wait_fd(ok);
    nvec++;
    if (!ok) begin nfail++; $display("FAIL freeze_wait got none want frame_done"); end
    for (int f = 0; f < 4; f++) begin
      dp_exp = (f == 0) || (f == 2);
      if (f == 2) begin
        g0 = '{7'h06, 7'h3F, 7'h3F, 7'h3F};
        g1 = '{7'h06, 7'h00, 7'h00, 7'h00};
      end
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        e0 = exp_pins(k, dp_exp, 1'b0);
        e1 = exp_pins(k, dp_exp, 1'b1);
        nvec += 2;
        if (pins0 !== e0) begin nfail++; $display("FAIL freeze f%0d k%0d dut0 got %h want %h", f, k, pins0, e0); end
        if (pins1 !== e1) begin nfail++; $display("FAIL freeze f%0d k%0d dut1 got %h want %h", f, k, pins1, e1); end
        if (f == 0 && k == 8) begin
          freeze = 1'b1;
          value  = 16'h0001;
        end
        if (f == 1 && k == 4) freeze = 1'b0;
      end
    end
  endtask

  task automatic test_midframe_reset();
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nvec += 2;
    if (pins0 !== 13'h0000) begin nfail++; $display("FAIL mid_rst dut0 got %h want %h", pins0, 13'h0000); end
    if (pins1 !== 13'h1FFE) begin nfail++; $display("FAIL mid_rst dut1 got %h want %h", pins1, 13'h1FFE); end
    rst = 1'b0;
    g0 = '{7'h3F, 7'h3F, 7'h3F, 7'h3F};
    g1 = '{7'h3F, 7'h00, 7'h00, 7'h00};
    for (int f = 0; f < 2; f++) begin
      dp_exp = (f == 1);
      if (f == 1) begin
        g0 = '{7'h06, 7'h3F, 7'h3F, 7'h3F};
        g1 = '{7'h06, 7'h00, 7'h00, 7'h00};
      end
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        e0 = exp_pins(k, dp_exp, 1'b0);
        e1 = exp_pins(k, dp_exp, 1'b1);
        nvec += 2;
        if (pins0 !== e0) begin nfail++; $display("FAIL restart f%0d k%0d dut0 got %h want %h", f, k, pins0, e0); end
        if (pins1 !== e1) begin nfail++; $display("FAIL restart f%0d k%0d dut1 got %h want %h", f, k, pins1, e1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz_blank();
    test_tear_free();
    test_freeze();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
